fetch_ctrl: RTL and testbench

Sequencer for the fetch stage of the RV32IM pipeline. It drives the PC select/load controls of the fetch datapath, runs a single-outstanding request/grant/response handshake with instruction memory, and delivers fetched instructions to the IF/ID boundary. It resolves decode and execute redirects and decode stalls, and discards stale in-flight fetches.

---
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives PC select/load, runs a single-outstanding
// req/gnt/rvalid handshake with instruction memory, delivers instructions to
// IF/ID, and squashes fetches made stale by decode/execute redirects.
// The datapath PC resets to 32'h00000000; this block never drives the PC value.
module fetch_ctrl #(
  parameter logic [31:0] NOP      = 32'h00000013,
  // Reset value of the delivery counter, kept at 0 in normal use; a preload
  // lets the 32-bit wrap be exercised without 2^32 fetches.
  parameter logic [31:0] CNT_INIT = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redir_dec_i,
  input  logic        redir_alu_i,
  input  logic [31:0] pc_cur_i,
  output logic [1:0]  pc_sel_o,
  output logic        pc_en_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        flush_id_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, KILL} state_t;

  state_t      state;
  logic [31:0] hold_buf;
  logic        redir;
  logic        deliver;

  // A redirect is honoured everywhere except IDLE and beats any stall.
  assign redir   = (redir_alu_i | redir_dec_i) && (state != IDLE);
  // An instruction goes to IF/ID straight from memory or from the hold buffer.
  assign deliver = !redir && !stall_i &&
                   ((state == WAIT && imem_rvalid_i) || state == HOLD);

  // PC control and memory request, decoded from state and current inputs.
  always_comb begin
    pc_sel_o    = 2'b00;
    pc_en_o     = 1'b0;
    flush_id_o  = 1'b0;
    imem_req_o  = (state == REQ);
    imem_addr_o = pc_cur_i;
    if (redir) begin
      pc_en_o    = 1'b1;
      flush_id_o = 1'b1;
      pc_sel_o   = redir_alu_i ? 2'b10 : 2'b01;
    end else if (deliver) begin
      pc_en_o    = 1'b1;
    end
  end

  // Sequencer state plus the registered IF/ID outputs and delivery counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      hold_buf      <= NOP;
      instr_o       <= NOP;
      instr_valid_o <= 1'b0;
      fetch_cnt_o   <= CNT_INIT;
    end else begin
      // valid is a single-cycle pulse; NOP whenever nothing is delivered
      instr_valid_o <= 1'b0;
      instr_o       <= NOP;
      if (deliver) begin
        instr_valid_o <= 1'b1;
        instr_o       <= (state == HOLD) ? hold_buf : imem_rdata_i;
        fetch_cnt_o   <= fetch_cnt_o + 32'd1;
      end
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // stray rvalid here is a protocol error and is ignored
          if (imem_gnt_i) state <= redir ? KILL : WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (redir) begin
              state <= REQ;
            end else if (stall_i) begin
              hold_buf <= imem_rdata_i;
              state    <= HOLD;
            end else begin
              state <= REQ;
            end
          end else if (redir) begin
            state <= KILL;
          end
        end
        HOLD: begin
          if (redir || !stall_i) state <= REQ;
        end
        KILL: begin
          // The stale response retires the outstanding request even if a
          // further redirect lands in the same cycle; the PC already holds
          // the newest target, so waiting for another rvalid would hang.
          if (imem_rvalid_i) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed handshake/stall/redirect/reset sequences,
// then randomized memory latency, stalls and redirects checked by a scoreboard
// holding the architectural instruction stream (target, target+4, ...).
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redir_dec, redir_alu;
  logic [31:0] pc_cur, dec_tgt, alu_tgt;
  logic [1:0]  pc_sel;
  logic        pc_en, req, gnt, rvalid, ivalid, flush;
  logic [31:0] addr, rdata, instr, cnt;

  // second instance, counter preloaded to all-ones for the wrap check
  logic        zero = 1'b0;
  logic [1:0]  pc_sel_w;
  logic        pc_en_w, req_w, ivalid_w, flush_w;
  logic [31:0] addr_w, instr_w, cnt_w;

  int n_chk = 0, n_pass = 0, n_deliv = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redir_dec_i(redir_dec),
    .redir_alu_i(redir_alu), .pc_cur_i(pc_cur), .pc_sel_o(pc_sel),
    .pc_en_o(pc_en), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_o(instr), .instr_valid_o(ivalid), .flush_id_o(flush),
    .fetch_cnt_o(cnt)
  );

  fetch_ctrl #(.CNT_INIT(32'hFFFFFFFF)) dut_w (
    .clk(clk), .rst(rst), .stall_i(zero), .redir_dec_i(zero),
    .redir_alu_i(zero), .pc_cur_i(pc_cur), .pc_sel_o(pc_sel_w),
    .pc_en_o(pc_en_w), .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_o(instr_w), .instr_valid_o(ivalid_w), .flush_id_o(flush_w),
    .fetch_cnt_o(cnt_w)
  );

  // instruction memory contents: a bijective hash of the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h7F4A7C15;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // fetch datapath PC register
  always @(posedge clk or negedge rst)
    if (!rst) pc_cur <= 32'h0;
    else if (pc_en)
      case (pc_sel)
        2'b01:   pc_cur <= dec_tgt;
        2'b10:   pc_cur <= alu_tgt;
        default: pc_cur <= pc_cur + 32'd4;
      endcase

  // scoreboard monitor
  always @(negedge clk) begin
    if (chk_en) begin
      if (ivalid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got instr %h want no delivery", instr);
        end else begin
          chk("sb_instr", instr, exp_q.pop_front());
        end
        exp_cnt = exp_cnt + 32'd1;
        n_deliv++;
        chk("sb_cnt", cnt, exp_cnt);
      end else begin
        chk("sb_nop", instr, NOP);
        chk("sb_cnt_hold", cnt, exp_cnt);
      end
      if (redir_alu || redir_dec)
        chk("sb_redir_ctl", 32'({pc_en, flush, pc_sel}),
            32'({2'b11, (redir_alu ? 2'b10 : 2'b01)}));
      else
        chk("sb_no_flush", 32'(flush), 32'h0);
      if (req) chk("sb_addr", addr, pc_cur);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        busy, pend_flush;
    logic [31:0] maddr, nxt_pc, pend_tgt;
    int          lat;

    rst = 1'b0; stall = 1'b0; redir_dec = 1'b0; redir_alu = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; dec_tgt = 32'h0; alu_tgt = 32'h0;

    // reset values
    repeat (2) cyc();
    smp();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_ctl", 32'({pc_en, flush, pc_sel}), 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(ivalid), 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_cnt_w", cnt_w, 32'hFFFFFFFF);

    // startup: zero-wait memory
    cyc(); rst = 1'b1; smp();
    chk("idle_req", 32'(req), 32'h0);
    cyc(); gnt = 1'b1; smp();
    chk("start_req", 32'(req), 32'h1);
    chk("start_addr", addr, 32'h0);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00500093; smp();
    chk("first_pcen", 32'({pc_en, flush, pc_sel}), 32'b1000);
    chk("wait_noreq", 32'(req), 32'h0);
    cyc(); rvalid = 1'b0; gnt = 1'b1; smp();
    chk("first_valid", 32'(ivalid), 32'h1);
    chk("first_instr", instr, 32'h00500093);
    chk("first_cnt", cnt, 32'h1);
    chk("next_addr", addr, 32'h4);
    chk("wrap_cnt", cnt_w, 32'h0);
    chk("wrap_valid", 32'({ivalid_w, req_w, pc_en_w, flush_w, pc_sel_w}), 32'b110000);
    chk("wrap_instr", instr_w, 32'h00500093);
    chk("wrap_addr", addr_w, 32'h4);

    // stall across rvalid, held 3 cycles
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA5A50013; stall = 1'b1; smp();
    chk("stall_ctl", 32'({pc_en, flush, pc_sel}), 32'h0);
    chk("stall_req", 32'(req), 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(); rvalid = 1'b0; smp();
      chk("hold_ctl", 32'({pc_en, flush, pc_sel}), 32'h0);
      chk("hold_req", 32'(req), 32'h0);
      chk("hold_valid", 32'(ivalid), 32'h0);
    end
    cyc(); stall = 1'b0; smp();
    chk("unstall_pcen", 32'({pc_en, flush, pc_sel}), 32'b1000);
    chk("unstall_valid", 32'(ivalid), 32'h0);
    cyc(); smp();
    chk("held_valid", 32'(ivalid), 32'h1);
    chk("held_instr", instr, 32'hA5A50013);
    chk("held_cnt", cnt, 32'h2);
    chk("held_addr", addr, 32'h8);
    cyc(); smp();
    chk("held_once", 32'({ivalid, req}), 32'b01);
    chk("held_once_cnt", cnt, 32'h2);

    // execute redirect with a fetch in flight
    cyc(); gnt = 1'b1; smp();
    cyc(); gnt = 1'b0; redir_alu = 1'b1; alu_tgt = 32'h100; smp();
    chk("redir_ctl", 32'({pc_en, flush, pc_sel}), 32'b1110);
    cyc(); redir_alu = 1'b0; smp();
    chk("kill_ctl", 32'({pc_en, flush, pc_sel, req, ivalid}), 32'h0);
    cyc(); rvalid = 1'b1; rdata = 32'hDEAD0013; smp();
    chk("kill_rv_ctl", 32'({pc_en, req}), 32'h0);
    cyc(); rvalid = 1'b0; smp();
    chk("stale_valid", 32'(ivalid), 32'h0);
    chk("stale_cnt", cnt, 32'h2);
    chk("redir_req", 32'(req), 32'h1);
    chk("redir_addr", addr, 32'h100);

    // both redirects together, with stall and rvalid
    cyc(); gnt = 1'b1; smp();
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hBEEF0013; stall = 1'b1;
    redir_dec = 1'b1; redir_alu = 1'b1; dec_tgt = 32'h200; alu_tgt = 32'h300; smp();
    chk("both_ctl", 32'({pc_en, flush, pc_sel}), 32'b1110);
    cyc(); rvalid = 1'b0; stall = 1'b0; redir_dec = 1'b0; redir_alu = 1'b0; smp();
    chk("both_valid", 32'(ivalid), 32'h0);
    chk("both_req", 32'(req), 32'h1);
    chk("both_addr", addr, 32'h300);
    chk("both_cnt", cnt, 32'h2);

    // reset while WAIT, late rvalid afterwards
    cyc(); gnt = 1'b1; smp();
    cyc(); gnt = 1'b0; smp();
    #1 rst = 1'b0; #1;
    chk("mid_rst_ctl", 32'({req, pc_en, flush, pc_sel, ivalid}), 32'h0);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_cnt", cnt, 32'h0);
    cyc(); rvalid = 1'b1; rdata = 32'h11110013; smp();
    chk("late_rv_rst", 32'({ivalid, req}), 32'h0);
    cyc(); rst = 1'b1; smp();
    chk("late_rv_idle", 32'({ivalid, req}), 32'h0);
    cyc(); smp();
    chk("late_rv_req", 32'({ivalid, req}), 32'b01);
    cyc(); rvalid = 1'b0; smp();
    chk("late_rv_after", 32'({ivalid, req}), 32'b01);
    chk("late_rv_cnt", cnt, 32'h0);
    chk("late_rv_instr", instr, NOP);

    // randomized phase: DUT is in REQ at PC 0 with nothing outstanding
    busy = 1'b0; pend_flush = 1'b0; nxt_pc = 32'h0; pend_tgt = 32'h0;
    maddr = 32'h0; lat = 0; exp_cnt = 32'h0;
    chk_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (pend_flush) begin
        exp_q.delete();
        nxt_pc = pend_tgt;
        pend_flush = 1'b0;
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(memf(nxt_pc));
        nxt_pc = nxt_pc + 32'd4;
      end
      rvalid = 1'b0;
      if (busy) begin
        if (lat == 0) begin
          rvalid = 1'b1;
          rdata  = memf(maddr);
          busy   = 1'b0;
        end else begin
          lat--;
        end
      end
      stall     = ($urandom_range(3) == 0);
      redir_alu = ($urandom_range(23) == 0);
      redir_dec = ($urandom_range(23) == 0);
      alu_tgt   = $urandom & 32'hFFFFFFFC;
      dec_tgt   = $urandom & 32'hFFFFFFFC;
      if (redir_alu || redir_dec) begin
        pend_flush = 1'b1;
        pend_tgt   = redir_alu ? alu_tgt : dec_tgt;
      end
      gnt = 1'b0;
      if (req && !busy && $urandom_range(2) != 0) begin
        gnt   = 1'b1;
        busy  = 1'b1;
        maddr = addr;
        lat   = $urandom_range(2);
      end
    end
    cyc();
    stall = 1'b0; redir_alu = 1'b0; redir_dec = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    smp();
    chk_en = 1'b0;
    chk("progress", 32'(n_deliv >= 100), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
